// File: rtl/commit_stage_if.sv
// Commit-stage bundle: EC pipeline register outputs, register-file write port,
// data-memory store handshake and status/forwarding outputs.
interface commit_stage_if;
   logic        mem_store_EC;
   logic        reg_write_en_EC;
   logic [3:0]  reg_write_addr_EC;
   logic [11:0] execute_result_EC;
   logic [11:0] instruction_EC;
   logic [9:0]  pc_plus_1_EC;
   logic        dmem_ack;

   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [11:0] rf_wdata;
   logic        dmem_req;
   logic [7:0]  dmem_addr;
   logic [11:0] dmem_wdata;
   logic        stall_commit;
   logic        fwd_valid;
   logic [3:0]  fwd_addr;
   logic [11:0] fwd_data;
   logic [9:0]  commit_pc;
   logic [15:0] retire_count;
   logic        timeout_err;

   modport master (
      output mem_store_EC, reg_write_en_EC, reg_write_addr_EC, execute_result_EC,
             instruction_EC, pc_plus_1_EC, dmem_ack,
      input  rf_we, rf_waddr, rf_wdata, dmem_req, dmem_addr, dmem_wdata,
             stall_commit, fwd_valid, fwd_addr, fwd_data, commit_pc,
             retire_count, timeout_err
   );

   modport slave (
      input  mem_store_EC, reg_write_en_EC, reg_write_addr_EC, execute_result_EC,
             instruction_EC, pc_plus_1_EC, dmem_ack,
      output rf_we, rf_waddr, rf_wdata, dmem_req, dmem_addr, dmem_wdata,
             stall_commit, fwd_valid, fwd_addr, fwd_data, commit_pc,
             retire_count, timeout_err
   );
endinterface

// File: rtl/commit_stage.sv
// Final pipeline stage: retires one instruction per commit cycle, runs stores over
// a req/ack handshake. Define COMMIT_TIMEOUT_EN to bound the wait for dmem_ack.
//
// state | meaning
// IDLE  | commits non-store instructions combinationally; a store launches a request
// STORE | dmem_req held; commits on ack (or on timeout when enabled)
module commit_stage #(
   parameter logic [11:0] NOP            = 12'hB11,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input logic          clk,
   input logic          rst,
   commit_stage_if.slave bus
);

   typedef enum logic {IDLE, STORE} state_t;

   state_t      state;
   logic        commit;
   logic        timeout_hit;
   logic        dmem_req_q;
   logic [7:0]  dmem_addr_q;
   logic [11:0] dmem_wdata_q;
   logic [9:0]  commit_pc_q;
   logic [15:0] retire_count_q;

`ifdef COMMIT_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        timeout_err_q;

   assign timeout_hit = (state == STORE) && !bus.dmem_ack &&
                        (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state == IDLE)
            wait_cnt <= '0;
         else if (!bus.dmem_ack)
            wait_cnt <= wait_cnt + 16'd1;
         if (timeout_hit)
            timeout_err_q <= 1'b1;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   assign timeout_hit     = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   always_comb begin
      commit = 1'b0;
      case (state)
         IDLE:    commit = !bus.mem_store_EC;
         STORE:   commit = bus.dmem_ack || timeout_hit;
         default: commit = 1'b0;
      endcase
   end

   // Gated by rst so no write strobe escapes while reset is held.
   assign bus.rf_we        = rst & commit & bus.reg_write_en_EC;
   assign bus.rf_waddr     = bus.reg_write_addr_EC;
   assign bus.rf_wdata     = bus.execute_result_EC;
   assign bus.fwd_valid    = bus.rf_we;
   assign bus.fwd_addr     = bus.rf_waddr;
   assign bus.fwd_data     = bus.rf_wdata;
   assign bus.stall_commit = !commit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         dmem_req_q     <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         commit_pc_q    <= '0;
         retire_count_q <= '0;
      end else begin
         if (commit) begin
            commit_pc_q <= bus.pc_plus_1_EC;
            if (bus.instruction_EC != NOP)
               retire_count_q <= retire_count_q + 16'd1;
         end
         case (state)
            IDLE: begin
               if (bus.mem_store_EC) begin
                  state        <= STORE;
                  dmem_req_q   <= 1'b1;
                  dmem_addr_q  <= bus.instruction_EC[7:0];
                  dmem_wdata_q <= bus.execute_result_EC;
               end
            end
            STORE: begin
               if (commit) begin
                  state      <= IDLE;
                  dmem_req_q <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               dmem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dmem_req     = dmem_req_q;
   assign bus.dmem_addr    = dmem_addr_q;
   assign bus.dmem_wdata   = dmem_wdata_q;
   assign bus.commit_pc    = commit_pc_q;
   assign bus.retire_count = retire_count_q;

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: vector table for plain commits, hand-written
// sequences for stores, reset mid-store, optional timeout and counter wrap.
module tb_commit_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   commit_stage_if bus ();

   commit_stage #(.NOP(12'hB11), .TIMEOUT_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [11:0] res;
      logic [11:0] instr;
      logic [9:0]  pc;
      logic [9:0]  exp_pc;
      logic [15:0] exp_rc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_ec(input logic st, input logic we, input logic [3:0] addr,
                         input logic [11:0] res, input logic [11:0] instr,
                         input logic [9:0] pc, input logic ack);
      bus.mem_store_EC      = st;
      bus.reg_write_en_EC   = we;
      bus.reg_write_addr_EC = addr;
      bus.execute_result_EC = res;
      bus.instruction_EC    = instr;
      bus.pc_plus_1_EC      = pc;
      bus.dmem_ack          = ack;
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      vecs[0] = '{1'b1, 4'h3, 12'h0A5, 12'h123, 10'h011, 10'h011, 16'd1};
      vecs[1] = '{1'b0, 4'h0, 12'h000, 12'hB11, 10'h012, 10'h012, 16'd1};
      vecs[2] = '{1'b0, 4'h0, 12'h000, 12'hB11, 10'h013, 10'h013, 16'd1};
      vecs[3] = '{1'b1, 4'h2, 12'h0F0, 12'hB11, 10'h014, 10'h014, 16'd1};
      vecs[4] = '{1'b0, 4'h0, 12'h000, 12'hB11, 10'h015, 10'h015, 16'd1};
      vecs[5] = '{1'b0, 4'h0, 12'h000, 12'hB11, 10'h016, 10'h016, 16'd1};
      vecs[6] = '{1'b0, 4'h0, 12'h000, 12'h200, 10'h017, 10'h017, 16'd2};
      vecs[7] = '{1'b1, 4'hF, 12'hFFF, 12'hB10, 10'h3FF, 10'h3FF, 16'd3};
      vecs[8] = '{1'b1, 4'h0, 12'h000, 12'hB12, 10'h000, 10'h000, 16'd4};

      // reset state, with a write request present to show rf_we is suppressed
      set_ec(1'b0, 1'b1, 4'h1, 12'h555, 12'hB11, 10'h000, 1'b0);
      #12;
      chk("rst_dmem_req", bus.dmem_req, 0);
      chk("rst_dmem_addr", bus.dmem_addr, 0);
      chk("rst_dmem_wdata", bus.dmem_wdata, 0);
      chk("rst_commit_pc", bus.commit_pc, 0);
      chk("rst_retire", bus.retire_count, 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
      chk("rst_rf_we", bus.rf_we, 0);
      chk("rst_fwd_valid", bus.fwd_valid, 0);
      @(negedge clk) rst = 1'b1;
      next_edge();
      chk("post_rst_nop_retire", bus.retire_count, 0);

      // plain commits, including a 5-long NOP stream
      for (int i = 0; i < 9; i++) begin
         set_ec(1'b0, vecs[i].we, vecs[i].addr, vecs[i].res, vecs[i].instr, vecs[i].pc, 1'b0);
         @(negedge clk);
         chk($sformatf("v%0d_rf_we", i), bus.rf_we, vecs[i].we);
         chk($sformatf("v%0d_fwd_valid", i), bus.fwd_valid, vecs[i].we);
         chk($sformatf("v%0d_stall", i), bus.stall_commit, 0);
         if (vecs[i].we) begin
            chk($sformatf("v%0d_rf_waddr", i), bus.rf_waddr, vecs[i].addr);
            chk($sformatf("v%0d_rf_wdata", i), bus.rf_wdata, vecs[i].res);
            chk($sformatf("v%0d_fwd_addr", i), bus.fwd_addr, vecs[i].addr);
            chk($sformatf("v%0d_fwd_data", i), bus.fwd_data, vecs[i].res);
         end
         next_edge();
         chk($sformatf("v%0d_commit_pc", i), bus.commit_pc, vecs[i].exp_pc);
         chk($sformatf("v%0d_retire", i), bus.retire_count, vecs[i].exp_rc);
         chk($sformatf("v%0d_dmem_req", i), bus.dmem_req, 0);
      end

      // store acked in the third STORE cycle
      set_ec(1'b1, 1'b0, 4'h0, 12'h7FF, 12'h8C4, 10'h020, 1'b0);
      @(negedge clk);
      chk("st_detect_stall", bus.stall_commit, 1);
      chk("st_detect_req", bus.dmem_req, 0);
      next_edge();
      chk("st_req", bus.dmem_req, 1);
      chk("st_addr", bus.dmem_addr, 8'hC4);
      chk("st_wdata", bus.dmem_wdata, 12'h7FF);
      chk("st_pc_held", bus.commit_pc, 10'h000);
      chk("st_rc_held", bus.retire_count, 4);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("st_wait_stall", bus.stall_commit, 1);
         next_edge();
         chk("st_wait_req", bus.dmem_req, 1);
         chk("st_wait_addr", bus.dmem_addr, 8'hC4);
      end
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      chk("st_ack_stall", bus.stall_commit, 0);
      chk("st_ack_rf_we", bus.rf_we, 0);
      next_edge();
      chk("st_done_req", bus.dmem_req, 0);
      chk("st_done_rc", bus.retire_count, 5);
      chk("st_done_pc", bus.commit_pc, 10'h020);

      // ack while IDLE is ignored; ordinary commit proceeds
      set_ec(1'b0, 1'b1, 4'h1, 12'h111, 12'h300, 10'h021, 1'b1);
      @(negedge clk);
      chk("idle_ack_stall", bus.stall_commit, 0);
      chk("idle_ack_rf_we", bus.rf_we, 1);
      next_edge();
      chk("idle_ack_req", bus.dmem_req, 0);
      chk("idle_ack_rc", bus.retire_count, 6);

      // store with register write: exactly one rf_we pulse, in the ack cycle
      set_ec(1'b1, 1'b1, 4'h5, 12'h0AB, 12'h8D2, 10'h030, 1'b0);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         bus.dmem_ack = (c == 3);
         @(negedge clk);
         if (bus.rf_we === 1'b1) pulses++;
         if (c == 3) begin
            chk("stw_ack_rf_we", bus.rf_we, 1);
            chk("stw_ack_waddr", bus.rf_waddr, 4'h5);
            chk("stw_ack_wdata", bus.rf_wdata, 12'h0AB);
         end
         next_edge();
      end
      chk("stw_pulses", pulses, 1);
      chk("stw_rc", bus.retire_count, 7);
      chk("stw_req", bus.dmem_req, 0);

`ifdef COMMIT_TIMEOUT_EN
      set_ec(1'b1, 1'b1, 4'h6, 12'h222, 12'h8E0, 10'h040, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("to_c%0d_stall", c), bus.stall_commit, (c == 4) ? 1'b0 : 1'b1);
         chk($sformatf("to_c%0d_rf_we", c), bus.rf_we, (c == 4) ? 1'b1 : 1'b0);
         next_edge();
      end
      chk("to_req", bus.dmem_req, 0);
      chk("to_err", bus.timeout_err, 1);
      chk("to_rc", bus.retire_count, 8);
      chk("to_pc", bus.commit_pc, 10'h040);
      set_ec(1'b0, 1'b0, 4'h0, 12'h000, 12'h301, 10'h041, 1'b0);
      @(negedge clk);
      chk("to_next_stall", bus.stall_commit, 0);
      next_edge();
      chk("to_next_rc", bus.retire_count, 9);
      chk("to_err_sticky", bus.timeout_err, 1);
`else
      chk("no_timeout_err", bus.timeout_err, 0);
`endif

      // reset asserted mid-store
      set_ec(1'b1, 1'b0, 4'h0, 12'h333, 12'h8C9, 10'h050, 1'b0);
      next_edge();
      chk("rs_req_before", bus.dmem_req, 1);
      #2 rst = 1'b0;
      #1;
      chk("rs_req", bus.dmem_req, 0);
      chk("rs_rc", bus.retire_count, 0);
      chk("rs_pc", bus.commit_pc, 0);
      chk("rs_err", bus.timeout_err, 0);
      set_ec(1'b0, 1'b1, 4'h7, 12'h123, 12'h123, 10'h060, 1'b0);
      chk("rs_rf_we", bus.rf_we, 0);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("rs_idle_stall", bus.stall_commit, 0);
      chk("rs_idle_rf_we", bus.rf_we, 1);
      next_edge();
      chk("rs_post_rc", bus.retire_count, 1);
      chk("rs_post_pc", bus.commit_pc, 10'h060);

      // retire counter wrap
      repeat (65534) @(posedge clk);
      #1;
      chk("wrap_ffff", bus.retire_count, 16'hFFFF);
      next_edge();
      chk("wrap_zero", bus.retire_count, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
